// File: rtl/ysyx_23060171_mem_arb_if.sv
// Request/response bus for one memory port: a request channel and a response channel, each with valid/ready.
// The master side issues requests; the slave side accepts them and returns responses.
interface ysyx_23060171_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  req_wen;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wmask;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_23060171_mem_arb.sv
// Round-robin arbiter that shares one memory port between the IFU and the LSU.
// Only one transaction is in flight at a time. Request fields and response data are held in registers.
//
// state | meaning
// IDLE  | waiting for a request; the winner's req_ready is driven combinationally
// REQ   | registered request presented to memory until mem accepts it
// RESP  | waiting for the memory response
// DONE  | response held for the owner until it is consumed
module ysyx_23060171_mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ysyx_23060171_mem_arb_if.slave         ifu,
    ysyx_23060171_mem_arb_if.slave         lsu,
    ysyx_23060171_mem_arb_if.master        mem,
    output logic                           owner,
    output logic [31:0]                    ifu_grant_cnt,
    output logic [31:0]                    lsu_grant_cnt
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t              state;
    logic                last_grant;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                mem_req_v_q;
    logic                mem_resp_r_q;
    logic                resp_v_q;
    logic                ifu_win;
    logic                lsu_win;

    // last_grant: 0 = IFU, 1 = LSU. On a tie, the master that was not served last wins.
    assign ifu_win = ifu.req_valid && (!lsu.req_valid || last_grant);
    assign lsu_win = lsu.req_valid && (!ifu.req_valid || !last_grant);

    assign ifu.req_ready = (state == IDLE) && ifu_win;
    assign lsu.req_ready = (state == IDLE) && lsu_win;

    assign mem.req_valid  = mem_req_v_q;
    assign mem.req_addr   = addr_q;
    assign mem.req_wen    = wen_q;
    assign mem.req_wdata  = wdata_q;
    assign mem.req_wmask  = wmask_q;
    assign mem.resp_ready = mem_resp_r_q;

    // Response data is visible only on the owner's port, and only while valid.
    assign ifu.resp_valid = resp_v_q && !owner;
    assign ifu.resp_rdata = (resp_v_q && !owner) ? rdata_q : '0;
    assign ifu.resp_err   = resp_v_q && !owner && err_q;
    assign lsu.resp_valid = resp_v_q && owner;
    assign lsu.resp_rdata = (resp_v_q && owner) ? rdata_q : '0;
    assign lsu.resp_err   = resp_v_q && owner && err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_grant    <= 1'b0;
            addr_q        <= '0;
            wen_q         <= 1'b0;
            wdata_q       <= '0;
            wmask_q       <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            mem_req_v_q   <= 1'b0;
            mem_resp_r_q  <= 1'b0;
            resp_v_q      <= 1'b0;
            ifu_grant_cnt <= '0;
            lsu_grant_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_win) begin
                        addr_q        <= lsu.req_addr;
                        wen_q         <= lsu.req_wen;
                        wdata_q       <= lsu.req_wdata;
                        wmask_q       <= lsu.req_wmask;
                        owner         <= 1'b1;
                        last_grant    <= 1'b1;
                        lsu_grant_cnt <= lsu_grant_cnt + 32'd1;
                        mem_req_v_q   <= 1'b1;
                        state         <= REQ;
                    end else if (ifu_win) begin
                        addr_q        <= ifu.req_addr;
                        wen_q         <= 1'b0;
                        wdata_q       <= '0;
                        wmask_q       <= '0;
                        owner         <= 1'b0;
                        last_grant    <= 1'b0;
                        ifu_grant_cnt <= ifu_grant_cnt + 32'd1;
                        mem_req_v_q   <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem.req_ready) begin
                        mem_req_v_q  <= 1'b0;
                        mem_resp_r_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (mem.resp_valid) begin
                        // A write returns no data to the LSU, whatever the memory drives.
                        rdata_q      <= (owner && wen_q) ? '0 : mem.resp_rdata;
                        err_q        <= mem.resp_err;
                        mem_resp_r_q <= 1'b0;
                        resp_v_q     <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (owner ? lsu.resp_ready : ifu.resp_ready) begin
                        resp_v_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
